// File: rtl/cnt_arbiter.sv
// cnt_arbiter: round-robin arbiter sharing one CW-bit up-counter among NREQ requesters.
// Define CNT_ARB_SAT_EN to make the counter saturate at all-ones instead of wrapping.
module cnt_arbiter #(
    parameter int NREQ = 4,
    parameter int CW = 2,
    localparam int IDW = (NREQ > 2) ? $clog2(NREQ) : 1
) (
    input  logic            clock,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    input  logic            clr,
    input  logic [CW-1:0]   target,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_id,
    output logic            busy,
    output logic [CW-1:0]   count,
    output logic            done,
    output logic            match,
    output logic            wrap,
    output logic            sat
);
    typedef enum logic {IDLE, GRANT} state_t;
    state_t state, state_nx;
    logic [IDW-1:0] ptr, win;
    logic [NREQ-1:0] rot;
    logic [CW-1:0] cnt_nx;
    logic take, inc, top;

    assign top = &count;
    assign match = count == target;
    assign rot = NREQ'({req, req} >> ptr);

    // Descending scan so the requester closest above ptr is written last and wins.
    always_comb begin
        win = ptr;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (rot[i]) win = IDW'((int'(ptr) + i) % NREQ);
        end
    end

    always_ff @(posedge clock) begin
        if (!rst_n) state <= IDLE;
        else state <= state_nx;
    end

    always_comb begin
        take = 1'b0;
        inc = 1'b0;
        state_nx = IDLE;
        if (state == IDLE) begin
            take = |req;
            state_nx = take ? GRANT : IDLE;
        end else begin
            inc = 1'b1;
        end
    end

`ifdef CNT_ARB_SAT_EN
    assign wrap = 1'b0;
    assign cnt_nx = (inc && !top) ? count + 1'b1 : count;
    always_ff @(posedge clock) begin
        sat <= (!rst_n || clr) ? 1'b0 : (inc && top) ? 1'b1 : sat;
    end
`else
    assign sat = 1'b0;
    assign cnt_nx = inc ? count + 1'b1 : count;
    always_ff @(posedge clock) begin
        wrap <= rst_n && inc && !clr && top;
    end
`endif

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            gnt <= '0;
            gnt_id <= '0;
            busy <= 1'b0;
            count <= '0;
            done <= 1'b0;
            ptr <= '0;
        end else begin
            gnt <= take ? NREQ'(1) << win : '0;
            busy <= take;
            if (take) gnt_id <= win;
            done <= inc;
            if (inc) ptr <= (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
            count <= clr ? '0 : cnt_nx;
        end
    end
endmodule
